aes_inv_key_sched: RTL and testbench

Inverse (decryption-direction) AES-128 key scheduler. It accepts a 128-bit cipher key, runs the forward schedule internally to reach the round-10 key, then walks the schedule backwards, emitting round keys 10 down to 0 one per handshake. It feeds the inverse-cipher datapath, which consumes round keys in reverse order, so a 1408-bit expanded-key buffer is not needed.

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/aes_subword.sv | 16 +
 rtl/aes_inv_key_sched.sv | 118 +++++++++++
 tb/tb_aes_inv_key_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants, state encoding and byte/word helpers for the AES-128 inverse key scheduler.
// Pure declarations: no latency, no backpressure.
// The S-box and rcon helpers are used by both the forward and the backward schedule steps.
package aes_pkg;

    localparam int NR = 10;

    localparam logic [7:0] RCON_FIRST = 8'h01;
    localparam logic [7:0] RCON_LAST  = 8'h36;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2,
        FIN  = 2'd3
    } state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte 0 of a word sits in bits [31:24]; RotWord moves it to the bottom.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon_fwd(input logic [7:0] rc);
        return (rc == 8'h80) ? 8'h1b : {rc[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] rcon_bwd(input logic [7:0] rc);
        return (rc == 8'h1b) ? 8'h80 : {1'b0, rc[7:1]};
    endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
// Purely combinational, zero latency.
// No handshake; the caller owns all flow control.
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);

    assign dout[31:24] = SBOX[din[31:24]];
    assign dout[23:16] = SBOX[din[23:16]];
    assign dout[15:8]  = SBOX[din[15:8]];
    assign dout[7:0]   = SBOX[din[7:0]];

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 round keys delivered in reverse order (10 down to 0) from a single 128-bit register.
// Latency: first key valid 11 cycles after start (load + 10 forward rounds), then one key per handshake.
// Backpressure: rk_out/rk_idx hold while rk_valid & !rk_ready; rk_valid only drops after key 0 is taken.
module aes_inv_key_sched
    import aes_pkg::*;
#(
    parameter int NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:127] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [0:127] rk_out,
    output logic [3:0]   rk_idx,
    output logic         done
);

    state_e       state_q;
    state_e       state_d;
    logic [0:127] key_q;
    logic [7:0]   rcon_q;
    logic [3:0]   cnt_q;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p1, p2, p3;
    logic [31:0]  f1, f2, f3;
    logic [31:0]  x0;
    logic [31:0]  sw_in;
    logic [31:0]  sw_out;
    logic         last_rnd;
    logic         hs;

    assign w0 = key_q[0:31];
    assign w1 = key_q[32:63];
    assign w2 = key_q[64:95];
    assign w3 = key_q[96:127];

    assign last_rnd = (cnt_q == 4'(NR));
    assign hs       = rk_valid & rk_ready;

    // Backward step recovers the previous round's w1..w3 by pairwise XOR.
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    // FWD and REV are exclusive, so one S-box bank serves both directions.
    assign sw_in = (state_q == REV) ? rot_word(p3) : rot_word(w3);

    aes_subword u_subword (
        .din  (sw_in),
        .dout (sw_out)
    );

    // Word 0 has the same form in both directions: w0 ^ SubWord(RotWord(.)) ^ rcon.
    assign x0 = w0 ^ sw_out ^ {rcon_q, 24'h0};
    assign f1 = w1 ^ x0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = FWD;
            FWD:  if (last_rnd) state_d = REV;
            REV:  if (hs && cnt_q == 4'd0) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            rcon_q  <= RCON_FIRST;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        key_q  <= key_in;
                        rcon_q <= RCON_FIRST;
                        cnt_q  <= 4'd1;
                    end
                end
                FWD: begin
                    key_q <= {x0, f1, f2, f3};
                    // On the last round cnt_q already reads NR, which is the first index emitted.
                    if (last_rnd) begin
                        rcon_q <= RCON_LAST;
                    end else begin
                        rcon_q <= rcon_fwd(rcon_q);
                        cnt_q  <= cnt_q + 4'd1;
                    end
                end
                REV: begin
                    if (hs && cnt_q != 4'd0) begin
                        key_q  <= {x0, p1, p2, p3};
                        rcon_q <= rcon_bwd(rcon_q);
                        cnt_q  <= cnt_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_q == FWD) || (state_q == REV);
    assign rk_valid = (state_q == REV);
    assign done     = (state_q == FIN);
    assign rk_out   = key_q;
    assign rk_idx   = cnt_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: known-answer table, random keys under random backpressure,
// and hand sequences for ignored starts, mid-schedule reset and back-to-back schedules.
module tb_aes_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    logic [7:0]   sbox_ref [256];
    logic [127:0] exp_rk [11];
    logic [127:0] cap [11];

    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [127:0] rk;
    } vec_t;

    vec_t vecs [8];

    aes_inv_key_sched #(.NR(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] b;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox_ref[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end
    endtask

    // Plain FIPS-197 key expansion into 44 words; round key r is words 4r..4r+3.
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One schedule. inj: pulse start with another key during FWD and REV.
    // abort_idx >= 0: assert rst while that index is presented. start_on_done: raise start in the done cycle.
    task automatic run_sched(input logic [127:0] key, input bit stall, input bit inj,
                             input int abort_idx, input bit start_on_done);
        int           cyc;
        int           nk;
        int           chg;
        int           d0;
        bit           was_stall;
        logic [127:0] hold_k;
        logic [3:0]   hold_i;
        logic [127:0] other;

        model_expand(key);
        other = ~key;
        d0 = done_cnt;
        key_in = key;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        key_in = other;
        cyc = 1;
        while (!rk_valid && cyc < 40) begin
            start = (inj && cyc == 5);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("latency", 128'(cyc), 128'd11);

        nk = 0;
        chg = 0;
        was_stall = 1'b0;
        hold_k = '0;
        hold_i = '0;
        while (nk < 11 && cyc < 400) begin
            if (!rk_valid) chg++;
            if (was_stall && (rk_out !== hold_k || rk_idx !== hold_i)) chg++;
            if (abort_idx >= 0 && rk_valid && rk_idx == 4'(abort_idx)) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                rk_ready = 1'b0;
                check("abort_valid", 128'(rk_valid), 128'd0);
                check("abort_busy", 128'(busy), 128'd0);
                check("abort_rk_out", rk_out, 128'd0);
                check("abort_done", 128'(done), 128'd0);
                @(posedge clk); #1;
                check("abort_no_done_pulse", 128'(done_cnt - d0), 128'd0);
                return;
            end
            rk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (inj && nk == 4);
            if (rk_ready && rk_valid) begin
                check($sformatf("idx_%0d", 10 - nk), 128'(rk_idx), 128'(10 - nk));
                check($sformatf("rk_%0d", 10 - nk), rk_out, exp_rk[10 - nk]);
                cap[10 - nk] = rk_out;
                nk++;
                was_stall = 1'b0;
            end else begin
                was_stall = 1'b1;
                hold_k = rk_out;
                hold_i = rk_idx;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        rk_ready = 1'b0;
        check("handshakes", 128'(nk), 128'd11);
        check("hold_and_valid", 128'(chg), 128'd0);
        check("done_after_key0", 128'(done), 128'd1);
        check("valid_low_at_done", 128'(rk_valid), 128'd0);
        check("busy_low_at_done", 128'(busy), 128'd0);
        check("rk_out_is_key", rk_out, key);
        if (start_on_done) begin
            start = 1'b1;
            key_in = other;
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (start_on_done) check("start_at_done_ignored", 128'(busy), 128'd0);
        check("done_one_cycle", 128'(done), 128'd0);
        check("single_done", 128'(done_cnt - d0), 128'd1);
    endtask

    initial begin
        logic [127:0] rk;
        rst = 1'b1;
        start = 1'b0;
        rk_ready = 1'b0;
        key_in = '0;
        build_sbox();

        vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f, idx: 10, rk: 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f, idx: 9,  rk: 128'h549932d1f08557681093ed9cbe2c974e};
        vecs[2] = '{key: 128'h000102030405060708090a0b0c0d0e0f, idx: 1,  rk: 128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
        vecs[3] = '{key: 128'h000102030405060708090a0b0c0d0e0f, idx: 0,  rk: 128'h000102030405060708090a0b0c0d0e0f};
        vecs[4] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, idx: 10, rk: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[5] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, idx: 9,  rk: 128'hac7766f319fadc2128d12941575c006e};
        vecs[6] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, idx: 1,  rk: 128'ha0fafe1788542cb123a339392a6c7605};
        vecs[7] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, idx: 0,  rk: 128'h2b7e151628aed2a6abf7158809cf4f3c};

        repeat (3) @(posedge clk);
        #1;
        check("reset_rk_valid", 128'(rk_valid), 128'd0);
        check("reset_rk_out", rk_out, 128'd0);
        check("reset_rk_idx", 128'(rk_idx), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Consecutive runs start the cycle after done, so these also cover back-to-back schedules.
        for (int v = 0; v < 8; v++) begin
            run_sched(vecs[v].key, 1'b0, 1'b0, -1, 1'b0);
            check($sformatf("table_%0d_idx%0d", v, vecs[v].idx), cap[vecs[v].idx], vecs[v].rk);
        end

        for (int n = 0; n < 6; n++)
            run_sched({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 1'b0, -1, 1'b0);

        run_sched(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, 1'b0, -1, 1'b0);
        check("stall_same_as_nostall", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run_sched({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b1, -1, 1'b0);
        run_sched({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 1'b1, -1, 1'b1);

        run_sched(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b0, 5, 1'b0);
        run_sched(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b0, -1, 1'b0);
        rk = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        check("after_abort_idx10", cap[10], rk);
        run_sched({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 1'b0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
